// File: rtl/dwt_d4_mac_pipe.sv
// Daubechies-4 analysis MAC: one (low, high) coefficient pair per input pixel pair,
// with periodic/symmetric end-of-line extension, round-half-up and output saturation.
module dwt_d4_mac_pipe #(
  parameter int PIXEL_W   = 8,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int OUT_W     = 16,
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 256,
  parameter logic signed [COEF_W-1:0] H0 = COEF_W'(7913),
  parameter logic signed [COEF_W-1:0] H1 = COEF_W'(13705),
  parameter logic signed [COEF_W-1:0] H2 = COEF_W'(3672),
  parameter logic signed [COEF_W-1:0] H3 = COEF_W'(-2120),
  // row/column and pixel pointers share one port width
  localparam int PW = $clog2((WIDTH > HEIGHT) ? WIDTH : HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*PIXEL_W-1:0] i_data,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 last_pixel,
  input  logic                 i_mode,
  input  logic [PW-1:0]        i_row_column_pointer,
  input  logic [PW-1:0]        i_pixel_pointer,
  output logic [OUT_W-1:0]     o_low,
  output logic [OUT_W-1:0]     o_high,
  output logic                 o_valid,
  output logic [PW-1:0]        o_row_column_pointer,
  output logic [PW-1:0]        o_pixel_pointer
);

  localparam int AW = PIXEL_W + COEF_W + 3;
  typedef logic signed [AW-1:0] acc_t;

  localparam logic signed [COEF_W-1:0] HC [4] = '{H0, H1, H2, H3};
  localparam logic signed [COEF_W-1:0] GC [4] = '{H3, -H2, H1, -H0};
  localparam acc_t RND  = acc_t'(2**(COEF_FRAC-1));
  localparam acc_t OMAX = acc_t'(2**(OUT_W-1) - 1);
  localparam acc_t OMIN = -OMAX - acc_t'(1);

  // state | meaning
  // EMPTY | no pair held; next accepted pair starts a line
  // HOLD  | prev pair held, waiting for its successor
  // FLUSH | input stalled one cycle, last pair launched with extension taps
  typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;

  function automatic acc_t pix_ext(input logic [PIXEL_W-1:0] p);
    return acc_t'({{(AW-PIXEL_W){1'b0}}, p});
  endfunction

  function automatic acc_t coef_ext(input logic signed [COEF_W-1:0] c);
    return acc_t'({{(AW-COEF_W){c[COEF_W-1]}}, c});
  endfunction

  function automatic logic [OUT_W-1:0] sat(input acc_t v);
    if (v > OMAX)      return OMAX[OUT_W-1:0];
    else if (v < OMIN) return OMIN[OUT_W-1:0];
    else               return v[OUT_W-1:0];
  endfunction

  state_t state_q, state_d;
  logic [2*PIXEL_W-1:0] prev_q, first_q;
  logic [PW-1:0]        prev_pix_q, prev_row_q;
  logic                 mode_q;

  logic                 accept, launch;
  logic [PIXEL_W-1:0]   tap_d [4];

  logic                 l_vld_q;
  logic [PIXEL_W-1:0]   tap_q [4];
  logic [PW-1:0]        l_pix_q, l_row_q;

  logic                 p_vld_q;
  acc_t                 prod_lo_q [4];
  acc_t                 prod_hi_q [4];
  logic [PW-1:0]        p_pix_q, p_row_q;

  logic                 s_vld_q;
  acc_t                 sum_lo_d, sum_hi_d, rnd_lo_d, rnd_hi_d;
  acc_t                 sum_lo_q, sum_hi_q;
  logic [PW-1:0]        s_pix_q, s_row_q;

  assign i_ready = !rst && (state_q != FLUSH);
  assign accept  = i_valid && i_ready;

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    tap_d[0] = prev_q[2*PIXEL_W-1:PIXEL_W];
    tap_d[1] = prev_q[PIXEL_W-1:0];
    tap_d[2] = i_data[2*PIXEL_W-1:PIXEL_W];
    tap_d[3] = i_data[PIXEL_W-1:0];
    case (state_q)
      EMPTY: begin
        if (accept) state_d = last_pixel ? FLUSH : HOLD;
      end
      HOLD: begin
        if (accept) begin
          launch  = 1'b1;
          state_d = last_pixel ? FLUSH : HOLD;
        end
      end
      FLUSH: begin
        launch  = 1'b1;
        state_d = EMPTY;
        if (mode_q) begin
          tap_d[2] = prev_q[PIXEL_W-1:0];
          tap_d[3] = prev_q[2*PIXEL_W-1:PIXEL_W];
        end else begin
          tap_d[2] = first_q[2*PIXEL_W-1:PIXEL_W];
          tap_d[3] = first_q[PIXEL_W-1:0];
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    sum_lo_d = RND;
    sum_hi_d = RND;
    for (int i = 0; i < 4; i++) begin
      sum_lo_d = sum_lo_d + prod_lo_q[i];
      sum_hi_d = sum_hi_d + prod_hi_q[i];
    end
    rnd_lo_d = sum_lo_d >>> COEF_FRAC;
    rnd_hi_d = sum_hi_d >>> COEF_FRAC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= EMPTY;
      prev_q               <= '0;
      first_q              <= '0;
      prev_pix_q           <= '0;
      prev_row_q           <= '0;
      mode_q               <= 1'b0;
      l_vld_q              <= 1'b0;
      l_pix_q              <= '0;
      l_row_q              <= '0;
      p_vld_q              <= 1'b0;
      p_pix_q              <= '0;
      p_row_q              <= '0;
      s_vld_q              <= 1'b0;
      sum_lo_q             <= '0;
      sum_hi_q             <= '0;
      s_pix_q              <= '0;
      s_row_q              <= '0;
      o_valid              <= 1'b0;
      o_low                <= '0;
      o_high               <= '0;
      o_pixel_pointer      <= '0;
      o_row_column_pointer <= '0;
      for (int i = 0; i < 4; i++) begin
        tap_q[i]     <= '0;
        prod_lo_q[i] <= '0;
        prod_hi_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        prev_q     <= i_data;
        prev_pix_q <= i_pixel_pointer;
        prev_row_q <= i_row_column_pointer;
      end
      if (accept && state_q == EMPTY) begin
        first_q <= i_data;
        mode_q  <= i_mode;
      end

      // launch: the output always carries the pointer of the older pair
      l_vld_q <= launch;
      if (launch) begin
        for (int i = 0; i < 4; i++) tap_q[i] <= tap_d[i];
        l_pix_q <= prev_pix_q;
        l_row_q <= prev_row_q;
      end

      p_vld_q <= l_vld_q;
      for (int i = 0; i < 4; i++) begin
        prod_lo_q[i] <= pix_ext(tap_q[i]) * coef_ext(HC[i]);
        prod_hi_q[i] <= pix_ext(tap_q[i]) * coef_ext(GC[i]);
      end
      p_pix_q <= l_pix_q;
      p_row_q <= l_row_q;

      s_vld_q  <= p_vld_q;
      sum_lo_q <= rnd_lo_d;
      sum_hi_q <= rnd_hi_d;
      s_pix_q  <= p_pix_q;
      s_row_q  <= p_row_q;

      o_valid <= s_vld_q;
      if (s_vld_q) begin
        o_low                <= sat(sum_lo_q);
        o_high               <= sat(sum_hi_q);
        o_pixel_pointer      <= s_pix_q;
        o_row_column_pointer <= s_row_q;
      end
    end
  end

endmodule

// File: tb/tb_dwt_d4_mac_pipe.sv
// Directed bench for dwt_d4_mac_pipe: hand-computed D4 coefficients, flush timing,
// saturation on an 8-bit-output instance, and mid-line reset.
module tb_dwt_d4_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_data;
  logic        i_valid, last_pixel, i_mode;
  logic [7:0]  i_row, i_pix;

  logic        i_ready, o_valid;
  logic [15:0] o_low, o_high;
  logic [7:0]  o_row, o_pix;

  logic        rdy8, vld8;
  logic [7:0]  low8, high8, row8, pix8;

  always #5 clk = ~clk;

  dwt_d4_mac_pipe dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .last_pixel(last_pixel), .i_mode(i_mode), .i_row_column_pointer(i_row),
    .i_pixel_pointer(i_pix), .o_low(o_low), .o_high(o_high), .o_valid(o_valid),
    .o_row_column_pointer(o_row), .o_pixel_pointer(o_pix)
  );

  dwt_d4_mac_pipe #(.OUT_W(8)) dut8 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(rdy8),
    .last_pixel(last_pixel), .i_mode(i_mode), .i_row_column_pointer(i_row),
    .i_pixel_pointer(i_pix), .o_low(low8), .o_high(high8), .o_valid(vld8),
    .o_row_column_pointer(row8), .o_pixel_pointer(pix8)
  );

  typedef struct {int lo; int hi; int pix; int row; int cyc;} out_t;
  out_t q[$];
  out_t q8[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (o_valid === 1'b1)
      q.push_back('{int'($signed(o_low)), int'($signed(o_high)), int'(o_pix), int'(o_row), cyc});
    if (vld8 === 1'b1)
      q8.push_back('{int'($signed(low8)), int'($signed(high8)), int'(pix8), int'(row8), cyc});
  end

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] pa [8];
  logic [7:0] pb [8];
  int t_acc [8];
  int exp_lo [8];
  int exp_hi [8];

  task automatic send(input int k, input int row, input bit last, input bit mode);
    bit ok;
    i_data = {pa[k], pb[k]};
    i_valid = 1'b1;
    last_pixel = last;
    i_mode = mode;
    i_pix = k[7:0];
    i_row = row[7:0];
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (i_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    t_acc[k] = cyc;
    i_valid = 1'b0;
    last_pixel = 1'b0;
  endtask

  task automatic run_line(input int p, input int row, input bit mode);
    q.delete();
    q8.delete();
    for (int k = 0; k < p; k++) send(k, row, k == p - 1, mode);
    @(negedge clk);
    chk("flush_rdy_lo", i_ready, 0);
    @(negedge clk);
    chk("flush_rdy_hi", i_ready, 1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_line(input string nm, input int p, input int row);
    int n;
    chk({nm, "_count"}, q.size(), p);
    n = (q.size() < p) ? q.size() : p;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_lo%0d", nm, k), q[k].lo, exp_lo[k]);
      chk($sformatf("%s_hi%0d", nm, k), q[k].hi, exp_hi[k]);
      chk($sformatf("%s_pix%0d", nm, k), q[k].pix, k);
      chk($sformatf("%s_row%0d", nm, k), q[k].row, row);
      chk($sformatf("%s_cyc%0d", nm, k), q[k].cyc,
          (k < p - 1) ? t_acc[k+1] + 3 : t_acc[p-1] + 4);
    end
  endtask

  task automatic set_const(input int v);
    for (int k = 0; k < 8; k++) begin
      pa[k] = v[7:0];
      pb[k] = v[7:0];
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 4; k++) begin
      pa[k] = 8'(2 * k);
      pb[k] = 8'(2 * k + 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_data = '0;
    i_valid = 1'b0;
    last_pixel = 1'b0;
    i_mode = 1'b0;
    i_row = '0;
    i_pix = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_low", o_low, 0);
    chk("rst_o_high", o_high, 0);
    chk("rst_o_pix", o_pix, 0);
    chk("rst_o_row", o_row, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_i_ready8", rdy8, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", i_ready, 1);
    @(posedge clk);
    #1;

    // constant 100, periodic
    set_const(100);
    for (int k = 0; k < 4; k++) begin exp_lo[k] = 141; exp_hi[k] = 0; end
    run_line(4, 1, 1'b0);
    check_line("const", 4, 1);

    // ramp 0..7, periodic
    set_ramp();
    exp_lo[0] = 1; exp_lo[1] = 4; exp_lo[2] = 7; exp_lo[3] = 9;
    exp_hi[0] = 0; exp_hi[1] = 0; exp_hi[2] = 0; exp_hi[3] = -3;
    run_line(4, 2, 1'b0);
    check_line("ramp_per", 4, 2);

    // ramp 0..7, symmetric
    exp_lo[3] = 10;
    exp_hi[3] = 1;
    run_line(4, 3, 1'b1);
    check_line("ramp_sym", 4, 3);

    // constant 255: 361 at OUT_W=16, saturates to 127 at OUT_W=8
    set_const(255);
    for (int k = 0; k < 2; k++) begin exp_lo[k] = 361; exp_hi[k] = 0; end
    run_line(2, 7, 1'b0);
    check_line("c255", 2, 7);
    chk("sat8_count", q8.size(), 2);
    for (int k = 0; k < q8.size() && k < 2; k++) begin
      chk($sformatf("sat8_lo%0d", k), q8[k].lo, 127);
      chk($sformatf("sat8_hi%0d", k), q8[k].hi, 0);
    end

    // single-pair line (10, 20), periodic
    pa[0] = 8'd10;
    pb[0] = 8'd20;
    exp_lo[0] = 21;
    exp_hi[0] = -7;
    run_line(1, 4, 1'b0);
    check_line("single", 1, 4);

    // reset after two pairs of a line
    set_const(50);
    q.delete();
    send(0, 5, 1'b0, 1'b0);
    send(1, 5, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_output", q.size(), 0);
    set_const(100);
    for (int k = 0; k < 4; k++) begin exp_lo[k] = 141; exp_hi[k] = 0; end
    run_line(4, 6, 1'b0);
    check_line("after_rst", 4, 6);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
